// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the IF/MEM memory port arbiter.
// Covers the FSM states, the requester encoding, the size encoding and the byte-lane helper.
package mem_arb_pkg;

    localparam int WORD_BYTES = 4;
    localparam int BYTE_W     = 8;

    localparam logic SIZE_BYTE = 1'b0;
    localparam logic SIZE_WORD = 1'b1;

    typedef enum logic [1:0] {
        IDLE,
        XFER,
        RESP
    } arb_state_e;

    typedef enum logic {
        REQ_IF,
        REQ_DM
    } req_e;

    // Attributes of the transaction in flight, latched at grant.
    typedef struct packed {
        req_e who;
        logic we;
        logic word;
    } xfer_t;

    // Big-endian lane for beat k: a word fills the top lane first, and a byte always uses lane 0.
    function automatic int unsigned lane_of(input logic word, input int unsigned k,
                                            input int unsigned wb);
        return word ? (wb - 32'd1 - k) : 32'd0;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Pipeline and memory-array signals of the shared memory port.
// The master side is the pipeline together with the array; the slave side is the arbiter.
interface mem_port_arbiter_if #(
    parameter int ADDR_W     = 8,
    parameter int WORD_BYTES = 4
);
    import mem_arb_pkg::*;

    localparam int DW = BYTE_W * WORD_BYTES;

    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic [DW-1:0]     if_rdata;
    logic              if_done;

    logic              dm_req;
    logic              dm_we;
    logic              dm_size;
    logic [ADDR_W-1:0] dm_addr;
    logic [DW-1:0]     dm_wdata;
    logic [DW-1:0]     dm_rdata;
    logic              dm_done;

    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [BYTE_W-1:0] mem_wdata;
    logic [BYTE_W-1:0] mem_rdata;

    logic              stall_if;
    logic              stall_mem;
    logic              busy;

    modport master (
        output if_req, if_addr, dm_req, dm_we, dm_size, dm_addr, dm_wdata, mem_rdata,
        input  if_rdata, if_done, dm_rdata, dm_done, mem_addr, mem_we, mem_wdata,
               stall_if, stall_mem, busy
    );

    modport slave (
        input  if_req, if_addr, dm_req, dm_we, dm_size, dm_addr, dm_wdata, mem_rdata,
        output if_rdata, if_done, dm_rdata, dm_done, mem_addr, mem_we, mem_wdata,
               stall_if, stall_mem, busy
    );

endinterface

// File: rtl/mem_port_arbiter.sv
// Arbitrates the fetch and load/store paths onto one byte-wide memory port.
// Each grant becomes a big-endian multi-beat transfer, followed by a one-cycle response.
module mem_port_arbiter #(
    parameter int ADDR_W     = 8,
    parameter int WORD_BYTES = mem_arb_pkg::WORD_BYTES
) (
    input logic               clk,
    input logic               reset,
    mem_port_arbiter_if.slave bus
);
    import mem_arb_pkg::*;

    localparam int DW = BYTE_W * WORD_BYTES;
    localparam int CW = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;

    arb_state_e        state;
    req_e              last_grant;
    xfer_t             cur;
    logic [ADDR_W-1:0] base;
    logic [DW-1:0]     wdata;
    logic [DW-1:0]     asm_q;
    logic [CW-1:0]     beat;
    logic [CW-1:0]     last_beat;

    logic [DW-1:0]     if_rdata_q;
    logic [DW-1:0]     dm_rdata_q;
    logic              if_done_q;
    logic              dm_done_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic              mem_we_q;
    logic [BYTE_W-1:0] mem_wdata_q;

    // Grant selection: on a tie, the side that was not served last wins.
    logic              grant_dm;
    xfer_t             g;
    logic [ADDR_W-1:0] g_addr;
    logic [DW-1:0]     asm_next;

    always_comb begin
        grant_dm = bus.dm_req & (~bus.if_req | (last_grant == REQ_IF));
        g.who    = grant_dm ? REQ_DM : REQ_IF;
        g.we     = grant_dm & bus.dm_we;
        g.word   = ~grant_dm | (bus.dm_size == SIZE_WORD);
        g_addr   = grant_dm ? bus.dm_addr : bus.if_addr;
    end

    // Merges the byte currently presented by the array into the assembly register.
    always_comb begin
        asm_next = asm_q;
        asm_next[lane_of(cur.word, 32'(beat), WORD_BYTES) * BYTE_W +: BYTE_W] = bus.mem_rdata;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= IDLE;
            last_grant  <= REQ_IF;
            cur         <= '{who: REQ_IF, we: 1'b0, word: 1'b0};
            base        <= '0;
            wdata       <= '0;
            asm_q       <= '0;
            beat        <= '0;
            last_beat   <= '0;
            if_rdata_q  <= '0;
            dm_rdata_q  <= '0;
            if_done_q   <= 1'b0;
            dm_done_q   <= 1'b0;
            mem_addr_q  <= '0;
            mem_we_q    <= 1'b0;
            mem_wdata_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if_done_q <= 1'b0;
                    dm_done_q <= 1'b0;
                    mem_we_q  <= 1'b0;
                    if (bus.if_req | bus.dm_req) begin
                        cur         <= g;
                        base        <= g_addr;
                        wdata       <= bus.dm_wdata;
                        asm_q       <= '0;
                        beat        <= '0;
                        last_beat   <= g.word ? CW'(WORD_BYTES - 1) : '0;
                        // Beat 0 is presented to the array in the very next cycle.
                        mem_addr_q  <= g_addr;
                        mem_we_q    <= g.we;
                        mem_wdata_q <= bus.dm_wdata[lane_of(g.word, 32'd0, WORD_BYTES) * BYTE_W +: BYTE_W];
                        state       <= XFER;
                    end
                end

                XFER: begin
                    asm_q <= asm_next;
                    if (beat == last_beat) begin
                        state      <= RESP;
                        mem_we_q   <= 1'b0;
                        mem_addr_q <= base;
                        last_grant <= cur.who;
                        if_done_q  <= (cur.who == REQ_IF);
                        dm_done_q  <= (cur.who == REQ_DM);
                        if (!cur.we) begin
                            if (cur.who == REQ_IF) if_rdata_q <= asm_next;
                            else                   dm_rdata_q <= asm_next;
                        end
                    end else begin
                        beat        <= beat + CW'(1);
                        mem_addr_q  <= base + ADDR_W'(beat) + ADDR_W'(1);
                        mem_wdata_q <= wdata[lane_of(cur.word, 32'(beat) + 32'd1, WORD_BYTES) * BYTE_W +: BYTE_W];
                    end
                end

                RESP: begin
                    if_done_q <= 1'b0;
                    dm_done_q <= 1'b0;
                    state     <= IDLE;
                end

                default: state <= IDLE;
            endcase
        end
    end

    assign bus.if_rdata  = if_rdata_q;
    assign bus.dm_rdata  = dm_rdata_q;
    assign bus.if_done   = if_done_q;
    assign bus.dm_done   = dm_done_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.stall_if  = bus.if_req & ~if_done_q;
    assign bus.stall_mem = bus.dm_req & ~dm_done_q;
    assign bus.busy      = (state != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a 256-byte memory model behind the port.
// Cycle 0 is the IDLE cycle in which a request is first presented.
module tb_mem_port_arbiter;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    mem_port_arbiter_if #(.ADDR_W(8), .WORD_BYTES(4)) bus ();

    mem_port_arbiter #(.ADDR_W(8), .WORD_BYTES(4)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] mem [256];
    logic       pre_we   = 1'b0;
    logic [7:0] pre_addr = '0;
    logic [7:0] pre_data = '0;

    always @(posedge clk) begin
        if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
        if (pre_we)     mem[pre_addr]     <= pre_data;
    end
    assign bus.mem_rdata = mem[bus.mem_addr];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mem_put(input logic [7:0] a, input logic [7:0] d);
        pre_we = 1'b1; pre_addr = a; pre_data = d;
        tick();
        pre_we = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        tick(); tick();
        n_tests++;
        if (bus.busy !== 1'b0 || bus.if_done !== 1'b0 || bus.dm_done !== 1'b0) begin
            n_fail++; $display("FAIL reset_flags: busy=%b if_done=%b dm_done=%b want 000", bus.busy, bus.if_done, bus.dm_done);
        end
        n_tests++;
        if (bus.mem_we !== 1'b0 || bus.mem_addr !== 8'h00 || bus.mem_wdata !== 8'h00) begin
            n_fail++; $display("FAIL reset_mem: we=%b addr=%h wdata=%h want 0 00 00", bus.mem_we, bus.mem_addr, bus.mem_wdata);
        end
        n_tests++;
        if (bus.if_rdata !== 32'h0 || bus.dm_rdata !== 32'h0) begin
            n_fail++; $display("FAIL reset_rdata: if=%h dm=%h want 0 0", bus.if_rdata, bus.dm_rdata);
        end
        reset = 1'b1;
        tick();
        n_tests++;
        if (bus.busy !== 1'b0 || bus.stall_if !== 1'b0 || bus.stall_mem !== 1'b0) begin
            n_fail++; $display("FAIL reset_idle: busy=%b stall_if=%b stall_mem=%b want 000", bus.busy, bus.stall_if, bus.stall_mem);
        end
    endtask

    task automatic test_fetch();
        mem_put(8'h10, 8'h11); mem_put(8'h11, 8'h22); mem_put(8'h12, 8'h33); mem_put(8'h13, 8'h44);
        bus.if_addr = 8'h10; bus.if_req = 1'b1;
        #1;
        n_tests++;
        if (bus.stall_if !== 1'b1) begin
            n_fail++; $display("FAIL fetch_stall c0: got %b want 1", bus.stall_if);
        end
        for (int c = 1; c <= 5; c++) begin
            tick();
            if (c <= 4) begin
                n_tests++;
                if (bus.mem_addr !== 8'(8'h10 + c - 1) || bus.mem_we !== 1'b0) begin
                    n_fail++; $display("FAIL fetch_beat c%0d: addr=%h we=%b want %h 0", c, bus.mem_addr, bus.mem_we, 8'(8'h10 + c - 1));
                end
                n_tests++;
                if (bus.stall_if !== 1'b1 || bus.if_done !== 1'b0) begin
                    n_fail++; $display("FAIL fetch_stall c%0d: stall=%b done=%b want 1 0", c, bus.stall_if, bus.if_done);
                end
            end else begin
                n_tests++;
                if (bus.if_done !== 1'b1 || bus.stall_if !== 1'b0) begin
                    n_fail++; $display("FAIL fetch_done c5: done=%b stall=%b want 1 0", bus.if_done, bus.stall_if);
                end
                n_tests++;
                if (bus.if_rdata !== 32'h11223344) begin
                    n_fail++; $display("FAIL fetch_rdata: got %h want 11223344", bus.if_rdata);
                end
            end
        end
        bus.if_req = 1'b0;
        tick();
        n_tests++;
        if (bus.if_done !== 1'b0 || bus.busy !== 1'b0 || bus.if_rdata !== 32'h11223344) begin
            n_fail++; $display("FAIL fetch_after: done=%b busy=%b rdata=%h want 0 0 11223344", bus.if_done, bus.busy, bus.if_rdata);
        end
    endtask

    task automatic test_store_load();
        logic [7:0] exp_b [4];
        exp_b[0] = 8'hA1; exp_b[1] = 8'hB2; exp_b[2] = 8'hC3; exp_b[3] = 8'hD4;
        bus.dm_addr = 8'h20; bus.dm_we = 1'b1; bus.dm_size = 1'b1; bus.dm_wdata = 32'hA1B2C3D4; bus.dm_req = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            tick();
            if (c <= 4) begin
                n_tests++;
                if (bus.mem_we !== 1'b1 || bus.mem_addr !== 8'(8'h20 + c - 1) || bus.mem_wdata !== exp_b[c-1]) begin
                    n_fail++; $display("FAIL store_beat c%0d: we=%b addr=%h data=%h want 1 %h %h",
                                       c, bus.mem_we, bus.mem_addr, bus.mem_wdata, 8'(8'h20 + c - 1), exp_b[c-1]);
                end
            end else begin
                n_tests++;
                if (bus.dm_done !== 1'b1 || bus.mem_we !== 1'b0 || bus.dm_rdata !== 32'h0) begin
                    n_fail++; $display("FAIL store_done: done=%b we=%b rdata=%h want 1 0 00000000", bus.dm_done, bus.mem_we, bus.dm_rdata);
                end
            end
        end
        bus.dm_req = 1'b0;
        tick();
        n_tests++;
        if (mem[8'h20] !== 8'hA1 || mem[8'h23] !== 8'hD4) begin
            n_fail++; $display("FAIL store_mem: [20]=%h [23]=%h want A1 D4", mem[8'h20], mem[8'h23]);
        end
        bus.dm_addr = 8'h22; bus.dm_we = 1'b0; bus.dm_size = 1'b0; bus.dm_req = 1'b1;
        tick();
        n_tests++;
        if (bus.mem_addr !== 8'h22 || bus.mem_we !== 1'b0 || bus.dm_done !== 1'b0) begin
            n_fail++; $display("FAIL bload_beat: addr=%h we=%b done=%b want 22 0 0", bus.mem_addr, bus.mem_we, bus.dm_done);
        end
        tick();
        n_tests++;
        if (bus.dm_done !== 1'b1 || bus.dm_rdata !== 32'h000000C3) begin
            n_fail++; $display("FAIL bload_done: done=%b rdata=%h want 1 000000C3", bus.dm_done, bus.dm_rdata);
        end
        bus.dm_req = 1'b0;
        tick();
    endtask

    task automatic test_byte_store();
        int we_cnt = 0;
        bus.dm_addr = 8'h30; bus.dm_we = 1'b1; bus.dm_size = 1'b0; bus.dm_wdata = 32'hFFFFFF5A; bus.dm_req = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            tick();
            if (bus.mem_we === 1'b1) we_cnt++;
            if (c == 1) begin
                n_tests++;
                if (bus.mem_we !== 1'b1 || bus.mem_addr !== 8'h30 || bus.mem_wdata !== 8'h5A) begin
                    n_fail++; $display("FAIL bstore_beat: we=%b addr=%h data=%h want 1 30 5A", bus.mem_we, bus.mem_addr, bus.mem_wdata);
                end
            end
            if (c == 2) begin
                n_tests++;
                if (bus.dm_done !== 1'b1 || bus.dm_rdata !== 32'h000000C3) begin
                    n_fail++; $display("FAIL bstore_done: done=%b rdata=%h want 1 000000C3", bus.dm_done, bus.dm_rdata);
                end
                bus.dm_req = 1'b0;
            end
        end
        n_tests++;
        if (we_cnt != 1 || mem[8'h30] !== 8'h5A) begin
            n_fail++; $display("FAIL bstore_count: we_beats=%0d mem30=%h want 1 5A", we_cnt, mem[8'h30]);
        end
    endtask

    task automatic test_wrap();
        logic [7:0] exp_a [4];
        exp_a[0] = 8'hFE; exp_a[1] = 8'hFF; exp_a[2] = 8'h00; exp_a[3] = 8'h01;
        mem_put(8'hFE, 8'h01); mem_put(8'hFF, 8'h02); mem_put(8'h00, 8'h03); mem_put(8'h01, 8'h04);
        bus.dm_addr = 8'hFE; bus.dm_we = 1'b0; bus.dm_size = 1'b1; bus.dm_req = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            tick();
            if (c <= 4) begin
                n_tests++;
                if (bus.mem_addr !== exp_a[c-1]) begin
                    n_fail++; $display("FAIL wrap_addr c%0d: got %h want %h", c, bus.mem_addr, exp_a[c-1]);
                end
            end else begin
                n_tests++;
                if (bus.dm_done !== 1'b1 || bus.dm_rdata !== 32'h01020304) begin
                    n_fail++; $display("FAIL wrap_done: done=%b rdata=%h want 1 01020304", bus.dm_done, bus.dm_rdata);
                end
            end
        end
        bus.dm_req = 1'b0;
        tick();
    endtask

    task automatic test_tie();
        int dm_cyc[$];
        int if_cyc[$];
        int d0, d1, i0, i1;
        reset = 1'b0; tick(); reset = 1'b1;
        bus.if_addr = 8'h10; bus.if_req = 1'b1;
        bus.dm_addr = 8'h20; bus.dm_we = 1'b0; bus.dm_size = 1'b1; bus.dm_req = 1'b1;
        for (int c = 1; c <= 24; c++) begin
            tick();
            if (bus.dm_done === 1'b1) begin
                dm_cyc.push_back(c);
                n_tests++;
                if (bus.dm_rdata !== 32'hA1B2C3D4) begin
                    n_fail++; $display("FAIL tie_dm_rdata c%0d: got %h want A1B2C3D4", c, bus.dm_rdata);
                end
            end
            if (bus.if_done === 1'b1) begin
                if_cyc.push_back(c);
                n_tests++;
                if (bus.if_rdata !== 32'h11223344) begin
                    n_fail++; $display("FAIL tie_if_rdata c%0d: got %h want 11223344", c, bus.if_rdata);
                end
            end
        end
        bus.if_req = 1'b0; bus.dm_req = 1'b0;
        for (int c = 0; c < 7; c++) tick();
        d0 = (dm_cyc.size() > 0) ? dm_cyc[0] : -1;
        d1 = (dm_cyc.size() > 1) ? dm_cyc[1] : -1;
        i0 = (if_cyc.size() > 0) ? if_cyc[0] : -1;
        i1 = (if_cyc.size() > 1) ? if_cyc[1] : -1;
        n_tests++;
        if (dm_cyc.size() != 2 || d0 != 5 || d1 != 17) begin
            n_fail++; $display("FAIL tie_dm_cycles: n=%0d first=%0d second=%0d want 2 5 17", dm_cyc.size(), d0, d1);
        end
        n_tests++;
        if (if_cyc.size() != 2 || i0 != 11 || i1 != 23) begin
            n_fail++; $display("FAIL tie_if_cycles: n=%0d first=%0d second=%0d want 2 11 23", if_cyc.size(), i0, i1);
        end
        n_tests++;
        if (bus.busy !== 1'b0) begin
            n_fail++; $display("FAIL tie_drain: busy=%b want 0", bus.busy);
        end
    endtask

    task automatic test_reset_mid();
        int bad = 0;
        mem_put(8'h40, 8'h00); mem_put(8'h41, 8'h00); mem_put(8'h42, 8'h00); mem_put(8'h43, 8'h00);
        bus.dm_addr = 8'h40; bus.dm_we = 1'b1; bus.dm_size = 1'b1; bus.dm_wdata = 32'hCAFEBABE; bus.dm_req = 1'b1;
        tick();
        tick();
        n_tests++;
        if (bus.mem_addr !== 8'h41 || bus.mem_we !== 1'b1) begin
            n_fail++; $display("FAIL rmid_beat1: addr=%h we=%b want 41 1", bus.mem_addr, bus.mem_we);
        end
        reset = 1'b0; bus.dm_req = 1'b0;
        tick();
        n_tests++;
        if (bus.busy !== 1'b0 || bus.mem_we !== 1'b0 || bus.dm_done !== 1'b0 || bus.dm_rdata !== 32'h0) begin
            n_fail++; $display("FAIL rmid_abort: busy=%b we=%b done=%b rdata=%h want 0 0 0 0",
                               bus.busy, bus.mem_we, bus.dm_done, bus.dm_rdata);
        end
        reset = 1'b1;
        for (int c = 0; c < 5; c++) begin
            tick();
            if (bus.mem_we !== 1'b0 || bus.dm_done !== 1'b0) bad++;
        end
        n_tests++;
        if (bad != 0) begin
            n_fail++; $display("FAIL rmid_quiet: %0d cycles with mem_we or dm_done, want 0", bad);
        end
        n_tests++;
        if (mem[8'h40] !== 8'hCA || mem[8'h41] !== 8'hFE || mem[8'h42] !== 8'h00 || mem[8'h43] !== 8'h00) begin
            n_fail++; $display("FAIL rmid_mem: %h %h %h %h want CA FE 00 00", mem[8'h40], mem[8'h41], mem[8'h42], mem[8'h43]);
        end
    endtask

    initial begin
        bus.if_req = 1'b0; bus.if_addr = '0;
        bus.dm_req = 1'b0; bus.dm_we = 1'b0; bus.dm_size = 1'b0; bus.dm_addr = '0; bus.dm_wdata = '0;
        test_reset();
        test_fetch();
        test_store_load();
        test_byte_store();
        test_wrap();
        test_tie();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
